adc_uart_tx: RTL

Serial transmitter for the ADC UART link: on a start strobe it latches four 16-bit channel words and sends them as four 3-byte packets (header, high byte, low byte) on a single serial line. It produces exactly the framing that `adc_uart_rx` consumes. It serves as the on-board ADC emulator for link bring-up, and as the loopback source for receiver regression and its valid/corrupt/timeout counters.

---
 rtl/adc_uart_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adc_uart_tx.sv
// rtl/adc_uart_tx.sv - ADC UART link transmitter: four 3-byte packets per burst, odd parity
// Serialises latched channel words as header/high/low bytes with a registered, glitch-free line.
module adc_uart_tx #(
   parameter int         CLKS_PER_BIT = 8,
   parameter logic [7:0] HEADER_BASE  = 8'h90,
   parameter int         STOP_BITS    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tx,
   input  logic [15:0] din0,
   input  logic [15:0] din1,
   input  logic [15:0] din2,
   input  logic [15:0] din3,
   input  logic        inject_parity_err,
   output logic        dout,
   output logic        busy,
   output logic        done,
   output logic [15:0] counter_bursts_sent
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

   localparam logic [7:0] T_LAST    = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] S_LAST    = 3'(STOP_BITS - 1);
   localparam logic [3:0] BYTE_LAST = 4'd11;

   state_t      state, state_next;
   logic [7:0]  timer, timer_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [3:0]  byte_idx, byte_idx_next;
   logic [15:0] word0, word1, word2, word3;
   logic        inj;
   logic [7:0]  cur_byte;
   logic        bit_end;
   logic        dout_next, busy_next, done_next;

   assign bit_end = (timer == T_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_tx) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && bit_idx == 3'd7) state_next = PARITY;
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (bit_end && bit_idx == S_LAST)
                     state_next = (byte_idx < BYTE_LAST) ? START : DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // bit_idx doubles as the stop-bit counter; it restarts on every state change
   always_comb begin
      timer_next    = (state == IDLE || state == DONE || bit_end) ? 8'd0 : timer + 8'd1;
      bit_idx_next  = bit_idx;
      byte_idx_next = byte_idx;
      if (state_next != state) bit_idx_next = 3'd0;
      else if (bit_end)        bit_idx_next = bit_idx + 3'd1;
      if (state == IDLE && start_tx)
         byte_idx_next = 4'd0;
      else if (state == STOP && state_next == START)
         byte_idx_next = byte_idx + 4'd1;
   end

   always_comb begin
      cur_byte = 8'hFF;
      case (byte_idx)
         4'd0:    cur_byte = HEADER_BASE;
         4'd1:    cur_byte = word0[15:8];
         4'd2:    cur_byte = word0[7:0];
         4'd3:    cur_byte = HEADER_BASE + 8'd1;
         4'd4:    cur_byte = word1[15:8];
         4'd5:    cur_byte = word1[7:0];
         4'd6:    cur_byte = HEADER_BASE + 8'd2;
         4'd7:    cur_byte = word2[15:8];
         4'd8:    cur_byte = word2[7:0];
         4'd9:    cur_byte = HEADER_BASE + 8'd3;
         4'd10:   cur_byte = word3[15:8];
         4'd11:   cur_byte = word3[7:0];
         default: cur_byte = 8'hFF;
      endcase
   end

   // Outputs are looked up from the next state so the flops present each bit on time
   always_comb begin
      dout_next = 1'b1;
      case (state_next)
         START:   dout_next = 1'b0;
         DATA:    dout_next = cur_byte[bit_idx_next];
         PARITY:  dout_next = (~^cur_byte) ^ inj;
         default: dout_next = 1'b1;
      endcase
      busy_next = (state_next != IDLE);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer               <= 8'd0;
         bit_idx             <= 3'd0;
         byte_idx            <= 4'd0;
         word0               <= 16'd0;
         word1               <= 16'd0;
         word2               <= 16'd0;
         word3               <= 16'd0;
         inj                 <= 1'b0;
         dout                <= 1'b1;
         busy                <= 1'b0;
         done                <= 1'b0;
         counter_bursts_sent <= 16'd0;
      end else begin
         timer    <= timer_next;
         bit_idx  <= bit_idx_next;
         byte_idx <= byte_idx_next;
         if (state == IDLE && start_tx) begin
            word0 <= din0;
            word1 <= din1;
            word2 <= din2;
            word3 <= din3;
            inj   <= inject_parity_err;
         end
         dout <= dout_next;
         busy <= busy_next;
         done <= done_next;
         if (state == STOP && state_next == DONE)
            counter_bursts_sent <= counter_bursts_sent + 16'd1;
      end
   end

endmodule
